// File: rtl/rx_prbs_checker.sv
// rx_prbs_checker
//   Self-seeding PRBS checker for 16:1 deserialized receive words. The
//   prediction for each incoming bit is formed from previously received
//   bits, so no seed or word alignment is needed. Lock can be acquired on
//   true or inverted data (swapped differential legs). Once locked, bit
//   errors and checked words are accumulated in saturating counters for
//   BER measurement.
//
// Ports
//   clk       in   recovered word clock (rising edge)
//   rst_n     in   asynchronous active-low reset
//   din       in   received word, din[W-1] earliest on the line
//   din_valid in   din qualified this cycle
//   clr_cnt   in   synchronous clear of err_cnt / word_cnt
//   locked    out  checker locked
//   inverted  out  lock was acquired on inverted data
//   err_flag  out  previous valid word had bit errors while locked
//   err_cnt   out  saturating bit error count while locked
//   word_cnt  out  saturating checked word count while locked
module rx_prbs_checker #(
    parameter int W        = 16,
    parameter int PRBS_N   = 31,
    parameter int PRBS_M   = 28,
    parameter int LOCK_CNT = 32,
    parameter int LOSS_THR = 4,
    parameter int LOSS_CNT = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             inverted,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);
    localparam int FILL = (PRBS_N + W - 1) / W;
    localparam int FW   = $clog2(FILL + 1);
    localparam int NW   = $clog2(W + 1);
    localparam int RW   = $clog2(LOCK_CNT + 1);
    localparam int BW   = $clog2(LOSS_CNT + 1);
    // Sum width wide enough for counter + popcount without wrapping.
    localparam int SW   = ((CNT_W > NW) ? CNT_W : NW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state;
    logic [PRBS_N-1:0] hist;       // hist[0] is the most recent received bit
    logic [FW-1:0]     fill;
    logic [RW-1:0]     clean_run;
    logic [RW-1:0]     inv_run;
    logic [BW-1:0]     bad_run;

    logic [W-1:0]      pred;
    logic [W-1:0]      raw_err;
    logic [W-1:0]      err_vec;
    logic [NW-1:0]     nerr;
    logic [SW-1:0]     err_sum;
    logic              full;

    // Bit din[j] sits j positions before the newest bit; its taps lie
    // PRBS_N and PRBS_M bits earlier, i.e. at hist[j+tap-W]. Since W is at
    // most PRBS_M, both taps always fall inside the history register.
    always_comb begin
        for (int j = 0; j < W; j++) begin
            pred[j] = hist[j + PRBS_N - W] ^ hist[j + PRBS_M - W];
        end
        raw_err = din ^ pred;
        err_vec = raw_err ^ {W{inverted}};
        nerr    = '0;
        for (int j = 0; j < W; j++) begin
            nerr = nerr + NW'(err_vec[j]);
        end
        err_sum = SW'(err_cnt) + SW'(nerr);
        full    = (fill == FW'(FILL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            hist      <= '0;
            fill      <= '0;
            clean_run <= '0;
            inv_run   <= '0;
            bad_run   <= '0;
            locked    <= 1'b0;
            inverted  <= 1'b0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            err_flag <= 1'b0;
            if (din_valid) begin
                hist <= {hist[PRBS_N-W-1:0], din};
                if (!full) begin
                    fill <= fill + FW'(1);
                end else if (state == SEARCH) begin
                    // Qualify on raw data: all-zero error is true PRBS,
                    // all-ones error is the same sequence inverted.
                    if (raw_err == '0) begin
                        inv_run <= '0;
                        if (clean_run == RW'(LOCK_CNT - 1)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            inverted  <= 1'b0;
                            clean_run <= '0;
                        end else begin
                            clean_run <= clean_run + RW'(1);
                        end
                    end else if (&raw_err) begin
                        clean_run <= '0;
                        if (inv_run == RW'(LOCK_CNT - 1)) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            inverted <= 1'b1;
                            inv_run  <= '0;
                        end else begin
                            inv_run <= inv_run + RW'(1);
                        end
                    end else begin
                        clean_run <= '0;
                        inv_run   <= '0;
                    end
                end else begin
                    err_flag <= (nerr != '0);
                    err_cnt  <= (err_sum > SW'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
                    if (word_cnt != CNT_MAX) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                    end
                    if (int'(nerr) >= LOSS_THR) begin
                        if (bad_run == BW'(LOSS_CNT - 1)) begin
                            state     <= SEARCH;
                            locked    <= 1'b0;
                            bad_run   <= '0;
                            clean_run <= '0;
                            inv_run   <= '0;
                        end else begin
                            bad_run <= bad_run + BW'(1);
                        end
                    end else begin
                        bad_run <= '0;
                    end
                end
            end
            // Clear wins over any increment of the same cycle.
            if (clr_cnt) begin
                err_cnt  <= '0;
                word_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx_prbs_checker.sv
module tb_rx_prbs_checker;
    localparam int W    = 16;
    localparam int N    = 31;
    localparam int M    = 28;
    localparam int LOCK = 32;
    localparam int THR  = 4;
    localparam int LOSS = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          locked, inverted, err_flag;
    logic [CW-1:0] err_cnt, word_cnt;

    always #5 clk = ~clk;

    rx_prbs_checker #(
        .W(W), .PRBS_N(N), .PRBS_M(M), .LOCK_CNT(LOCK),
        .LOSS_THR(THR), .LOSS_CNT(LOSS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .locked(locked), .inverted(inverted),
        .err_flag(err_flag), .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    typedef struct {
        int lk; int inv; int fl; int ec; int wc;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   npass = 0;

    task automatic check(string name, int act, int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Received bit stream in line order, plus word-level bookkeeping.
    bit rb[$];
    int mw, m_lk, m_inv, m_fl, m_ec, m_wc, m_clean, m_irun, m_bad;

    function automatic void model_reset();
        rb.delete();
        mw = 0; m_lk = 0; m_inv = 0; m_fl = 0; m_ec = 0; m_wc = 0;
        m_clean = 0; m_irun = 0; m_bad = 0;
    endfunction

    // Number of bits of d that disagree with b[n-N]^b[n-M] of the received stream.
    function automatic int raw_errs(logic [W-1:0] d);
        int s = rb.size();
        int r = 0;
        for (int k = 0; k < W; k++)
            if ((rb[s+k-N] ^ rb[s+k-M]) != d[W-1-k]) r++;
        return r;
    endfunction

    function automatic void model_step(logic v, logic [W-1:0] d, logic c);
        int r, ne;
        m_fl = 0;
        if (v) begin
            if (mw * W >= N) begin
                r = raw_errs(d);
                if (m_lk == 0) begin
                    if (r == 0) begin m_clean++; m_irun = 0; end
                    else if (r == W) begin m_irun++; m_clean = 0; end
                    else begin m_clean = 0; m_irun = 0; end
                    if (m_clean == LOCK) begin m_lk = 1; m_inv = 0; m_clean = 0; end
                    if (m_irun == LOCK) begin m_lk = 1; m_inv = 1; m_irun = 0; end
                end else begin
                    ne   = (m_inv != 0) ? W - r : r;
                    m_fl = (ne != 0);
                    m_wc = (m_wc + 1 > CMAX) ? CMAX : m_wc + 1;
                    m_ec = (m_ec + ne > CMAX) ? CMAX : m_ec + ne;
                    m_bad = (ne >= THR) ? m_bad + 1 : 0;
                    if (m_bad == LOSS) begin
                        m_lk = 0; m_bad = 0; m_clean = 0; m_irun = 0;
                    end
                end
            end
            for (int k = 0; k < W; k++) rb.push_back(d[W-1-k]);
            while (rb.size() > 64) void'(rb.pop_front());
            if (mw < 4) mw++;
        end
        if (c) begin m_ec = 0; m_wc = 0; end
    endfunction

    // ---------------- PRBS31 source (any seed) ----------------
    bit g[$];

    function automatic logic [W-1:0] gen_word(bit inv);
        logic [W-1:0] w;
        bit nb;
        for (int k = 0; k < W; k++) begin
            nb = g[g.size()-N] ^ g[g.size()-M];
            g.push_back(nb);
            w[W-1-k] = nb ^ inv;
        end
        while (g.size() > 64) void'(g.pop_front());
        return w;
    endfunction

    // Random word that is clearly bad (>= THR errors) against a true-data lock.
    function automatic logic [W-1:0] bad_word();
        logic [W-1:0] d;
        int r;
        d = W'($urandom);
        for (int t = 0; t < 100; t++) begin
            r = raw_errs(d);
            if (r >= THR && r <= W - THR) break;
            d = W'($urandom);
        end
        return d;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(logic v, logic [W-1:0] d, logic c);
        exp_t e;
        din = d; din_valid = v; clr_cnt = c;
        model_step(v, d, c);
        e.lk = m_lk; e.inv = m_inv; e.fl = m_fl; e.ec = m_ec; e.wc = m_wc;
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic run_prbs(int n, bit inv, int lock_at, string tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, gen_word(inv), 1'b0);
            if (i == lock_at - 2) check({tag, "_pre_lock"}, int'(locked), 0);
            if (i == lock_at - 1) begin
                check({tag, "_lock"}, int'(locked), 1);
                check({tag, "_inverted"}, int'(inverted), int'(inv));
            end
        end
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_locked"},   int'(locked),   0);
        check({tag, "_inverted"}, int'(inverted), 0);
        check({tag, "_err_flag"}, int'(err_flag), 0);
        check({tag, "_err_cnt"},  int'(err_cnt),  0);
        check({tag, "_word_cnt"}, int'(word_cnt), 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst");
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("mon_locked",   int'(locked),   e.lk);
                check("mon_inverted", int'(inverted), e.inv);
                check("mon_err_flag", int'(err_flag), e.fl);
                check("mon_err_cnt",  int'(err_cnt),  e.ec);
                check("mon_word_cnt", int'(word_cnt), e.wc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] w;
        model_reset();
        g.push_back(1'b1);
        for (int i = 1; i < N; i++) g.push_back(bit'($urandom_range(0, 1)));

        #12 check_zero_outputs("reset");
        rst_n = 1'b1;

        // Clean stream: 2 fill words + 32 qualifying words.
        run_prbs(40, 1'b0, 34, "clean");
        check("clean_word_cnt", int'(word_cnt), 6);
        check("clean_err_cnt",  int'(err_cnt),  0);

        // Single bit flip: own error plus the two taps that later read it.
        drive(1'b0, W'($urandom), 1'b1);
        run_prbs(4, 1'b0, 0, "pre_flip");
        w = gen_word(1'b0) ^ (W'(1) << $urandom_range(0, W-1));
        drive(1'b1, w, 1'b0);
        check("flip_err_flag", int'(err_flag), 1);
        run_prbs(4, 1'b0, 0, "post_flip");
        check("flip_err_cnt",  int'(err_cnt),  3);
        check("flip_word_cnt", int'(word_cnt), 9);
        check("flip_locked",   int'(locked),   1);

        // Idle gaps interleaved with clean words.
        drive(1'b0, W'($urandom), 1'b1);
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) drive(1'b1, gen_word(1'b0), 1'b0);
            else drive(1'b0, W'($urandom), 1'b0);
        end

        // Clear in the same cycle as an errored word.
        w = gen_word(1'b0) ^ (W'(1) << $urandom_range(0, W-1));
        drive(1'b1, w, 1'b1);
        check("clr_prio_err_cnt",  int'(err_cnt),  0);
        check("clr_prio_word_cnt", int'(word_cnt), 0);
        run_prbs(3, 1'b0, 0, "post_clr");

        // Error counter saturation: flip the latest bit of every word.
        drive(1'b0, W'($urandom), 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, gen_word(1'b0) ^ W'(1), 1'b0);
        check("sat_err_cnt",  int'(err_cnt),  CMAX);
        check("sat_word_cnt", int'(word_cnt), 12);
        check("sat_locked",   int'(locked),   1);
        run_prbs(4, 1'b0, 0, "post_sat");
        check("sat_hold", int'(err_cnt), CMAX);

        // Loss of lock on 8 bad words, then relock.
        drive(1'b0, W'($urandom), 1'b1);
        for (int i = 0; i < LOSS; i++) begin
            drive(1'b1, bad_word(), 1'b0);
            if (i == LOSS - 2) check("loss_pre", int'(locked), 1);
        end
        check("loss_locked",   int'(locked),   0);
        check("loss_word_cnt", int'(word_cnt), LOSS);
        run_prbs(40, 1'b0, 34, "relock");

        // Reset mid-stream, then inverted data.
        reset_pulse();
        run_prbs(40, 1'b1, 34, "inv");
        drive(1'b0, W'($urandom), 1'b1);
        run_prbs(8, 1'b1, 0, "inv_run");
        check("inv_err_cnt",  int'(err_cnt),  0);
        check("inv_word_cnt", int'(word_cnt), 8);

        @(negedge clk);
        #1 check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
